// File: rtl/traffic_pkg.sv
// ============================================================================
// Module      : traffic_pkg
// Description : Shared light encodings, fault codes and monitor states for
//               the traffic conflict monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] OFF    = 3'b000;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_INVALID      = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_SHORT_YELLOW = 3'd3,
        FC_SKIP_YELLOW  = 3'd4
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_MONITOR   = 2'd0,
        ST_FLASH     = 2'd1,
        ST_WAIT_SYNC = 2'd2
    } mon_state_e;

    // True for the three legal one-hot light codes
    function automatic logic is_valid(input logic [2:0] code);
        return (code == RED) || (code == YELLOW) || (code == GREEN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_conflict_monitor_flash_timer.sv
// ============================================================================
// Module      : tcm_flash_timer
// Description : Half-period counter for red-flash mode. phase_o=0 is the lit
//               phase; wrap_o flags the cycle on which the phase flips.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcm_flash_timer #(
    parameter int FLASH_HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic phase_o,
    output logic wrap_o
);

    localparam int CW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [CW-1:0] count_q;
    logic          phase_q;

    assign wrap_o  = en_i && (count_q == CW'(FLASH_HALF - 1));
    assign phase_o = phase_q;

    // Count cycles within a phase and flip the phase at each wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (clear_i) begin
            count_q <= '0;
            phase_q <= 1'b0;
        end else if (en_i) begin
            if (wrap_o) begin
                count_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_conflict_monitor.sv
// ============================================================================
// Module      : traffic_conflict_monitor
// Description : Safety stage between sequencer and lamp drivers. Forwards
//               light codes with one cycle latency, latches faults, forces
//               red flash until cleared, then resyncs to start of cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int PERSIST_CYC = 2,
    parameter int MIN_YELLOW  = 3,
    parameter int FLASH_HALF  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] roadA_in,
    input  logic [2:0] roadB_in,
    input  logic       fault_clear,
    output logic [2:0] lampA,
    output logic [2:0] lampB,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash_mode
);

    localparam int PW = $clog2(PERSIST_CYC + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);

    mon_state_e  state_q, state_d;
    logic [2:0]  lampA_q, lampA_d, lampB_q, lampB_d;
    logic [2:0]  prevA_q, prevB_q;
    logic        fault_q, fault_d, flash_q, flash_d;
    fault_code_e code_q, code_d;
    logic [PW-1:0] persist_q, persist_d;
    logic [YW-1:0] yelA_q, yelA_d, yelB_q, yelB_d;

    logic          w_inv, w_conf, w_bad, w_level;
    logic [PW-1:0] w_persist_inc;
    logic [YW-1:0] w_yelA_nx, w_yelB_nx;
    logic          w_shortA, w_shortB, w_skipA, w_skipB;
    fault_code_e   w_code;
    logic          w_phase, w_wrap;

    tcm_flash_timer #(.FLASH_HALF(FLASH_HALF)) u_flash_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q != ST_FLASH),
        .en_i    (state_q == ST_FLASH),
        .phase_o (w_phase),
        .wrap_o  (w_wrap)
    );

    // Level faults: illegal codes, or two roads showing non-red together
    assign w_inv         = !is_valid(roadA_in) || !is_valid(roadB_in);
    assign w_conf        = !w_inv && (roadA_in != RED) && (roadB_in != RED);
    assign w_bad         = w_inv || w_conf;
    assign w_persist_inc = persist_q + PW'(1);
    assign w_level       = w_bad && (w_persist_inc >= PW'(PERSIST_CYC));

    // Yellow run lengths saturate once the minimum has been met
    assign w_yelA_nx = (roadA_in != YELLOW) ? '0 :
                       (yelA_q == YW'(MIN_YELLOW)) ? yelA_q : yelA_q + YW'(1);
    assign w_yelB_nx = (roadB_in != YELLOW) ? '0 :
                       (yelB_q == YW'(MIN_YELLOW)) ? yelB_q : yelB_q + YW'(1);

    // Sequence faults judged against the previous sample
    assign w_shortA = (prevA_q == YELLOW) && (roadA_in == RED) && (yelA_q < YW'(MIN_YELLOW));
    assign w_shortB = (prevB_q == YELLOW) && (roadB_in == RED) && (yelB_q < YW'(MIN_YELLOW));
    assign w_skipA  = (prevA_q == GREEN) && (roadA_in == RED);
    assign w_skipB  = (prevB_q == GREEN) && (roadB_in == RED);

    // Pick the lowest-numbered fault present this cycle
    always_comb begin
        w_code = FC_NONE;
        if (w_level)
            w_code = w_inv ? FC_INVALID : FC_CONFLICT;
        else if (w_shortA || w_shortB)
            w_code = FC_SHORT_YELLOW;
        else if (w_skipA || w_skipB)
            w_code = FC_SKIP_YELLOW;
    end

    // Next-state and next-output decode for the monitor FSM
    always_comb begin
        state_d   = state_q;
        lampA_d   = lampA_q;
        lampB_d   = lampB_q;
        fault_d   = fault_q;
        code_d    = code_q;
        flash_d   = flash_q;
        persist_d = persist_q;
        yelA_d    = yelA_q;
        yelB_d    = yelB_q;
        case (state_q)
            ST_MONITOR: begin
                yelA_d = w_yelA_nx;
                yelB_d = w_yelB_nx;
                if (w_bad) begin
                    lampA_d   = RED;
                    lampB_d   = RED;
                    persist_d = w_persist_inc;
                end else begin
                    lampA_d   = roadA_in;
                    lampB_d   = roadB_in;
                    persist_d = '0;
                end
                if (w_code != FC_NONE) begin
                    state_d   = ST_FLASH;
                    fault_d   = 1'b1;
                    code_d    = w_code;
                    flash_d   = 1'b1;
                    lampA_d   = RED;
                    lampB_d   = RED;
                    persist_d = '0;
                    yelA_d    = '0;
                    yelB_d    = '0;
                end
            end
            ST_FLASH: begin
                // Lamp shows the phase the timer is about to enter
                lampA_d = (w_phase ^ w_wrap) ? OFF : RED;
                lampB_d = (w_phase ^ w_wrap) ? OFF : RED;
                if (fault_clear) begin
                    state_d = ST_WAIT_SYNC;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                    flash_d = 1'b0;
                    lampA_d = RED;
                    lampB_d = RED;
                end
            end
            ST_WAIT_SYNC: begin
                lampA_d   = RED;
                lampB_d   = RED;
                persist_d = '0;
                yelA_d    = '0;
                yelB_d    = '0;
                if ((roadA_in == GREEN) && (roadB_in == RED)) begin
                    state_d = ST_MONITOR;
                    lampA_d = roadA_in;
                    lampB_d = roadB_in;
                end
            end
            default: state_d = ST_MONITOR;
        endcase
    end

    // State, registered outputs and history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_MONITOR;
            lampA_q   <= RED;
            lampB_q   <= RED;
            prevA_q   <= RED;
            prevB_q   <= RED;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
            flash_q   <= 1'b0;
            persist_q <= '0;
            yelA_q    <= '0;
            yelB_q    <= '0;
        end else begin
            state_q   <= state_d;
            lampA_q   <= lampA_d;
            lampB_q   <= lampB_d;
            prevA_q   <= roadA_in;
            prevB_q   <= roadB_in;
            fault_q   <= fault_d;
            code_q    <= code_d;
            flash_q   <= flash_d;
            persist_q <= persist_d;
            yelA_q    <= yelA_d;
            yelB_q    <= yelB_d;
        end
    end

    assign lampA      = lampA_q;
    assign lampB      = lampB_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign flash_mode = flash_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_conflict_monitor.sv
// ============================================================================
// Module      : tb_traffic_conflict_monitor
// Description : Directed scoreboard bench for traffic_conflict_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_conflict_monitor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] roadA_in = RED;
    logic [2:0] roadB_in = RED;
    logic       fault_clear = 1'b0;
    logic [2:0] lampA, lampB, fault_code;
    logic       fault, flash_mode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [10:0] v;
    } exp_t;
    exp_t sb[$];

    traffic_conflict_monitor #(
        .PERSIST_CYC (2),
        .MIN_YELLOW  (3),
        .FLASH_HALF  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .roadA_in    (roadA_in),
        .roadB_in    (roadB_in),
        .fault_clear (fault_clear),
        .lampA       (lampA),
        .lampB       (lampB),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash_mode  (flash_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic [2:0] a, input logic [2:0] b,
                                       input logic f, input logic [2:0] c, input logic fm);
        return {a, b, f, c, fm};
    endfunction

    task automatic expect_push(input string tag, input logic [10:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
    endtask

    task automatic compare_front();
        exp_t        e;
        logic [10:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e   = sb.pop_front();
        obs = {lampA, lampB, fault, fault_code, flash_mode};
        assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (lampA lampB fault code flash)", e.tag, obs, e.v);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic clr, input logic [10:0] e);
        roadA_in    = a;
        roadB_in    = b;
        fault_clear = clr;
        expect_push(tag, e);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic pass(input string tag, input logic [2:0] a, input logic [2:0] b);
        step(tag, a, b, 1'b0, mk(a, b, 1'b0, 3'd0, 1'b0));
    endtask

    // Flash pattern: cycle k after the fault edge (which is k=0) is lit for k/4 even
    task automatic flash_run(input string tag, input int n, input logic [2:0] code);
        for (int k = 1; k <= n; k++) begin
            if (((k / 4) % 2) == 1)
                step(tag, RED, RED, 1'b0, mk(OFF, OFF, 1'b1, code, 1'b1));
            else
                step(tag, RED, RED, 1'b0, mk(RED, RED, 1'b1, code, 1'b1));
        end
    endtask

    task automatic recover();
        step("clear",     RED,    RED, 1'b1, mk(RED, RED, 1'b0, 3'd0, 1'b0));
        step("sync_hold", YELLOW, RED, 1'b0, mk(RED, RED, 1'b0, 3'd0, 1'b0));
        step("resync",    GREEN,  RED, 1'b0, mk(GREEN, RED, 1'b0, 3'd0, 1'b0));
    endtask

    initial begin
        // Asynchronous reset applied before any clock edge
        #1 reset = 1'b1;
        #2;
        expect_push("reset_state", mk(RED, RED, 1'b0, 3'd0, 1'b0));
        compare_front();
        #9 reset = 1'b0;

        // Nominal: three full sequencer cycles, clear ignored in MONITOR
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 6; i++) begin
                if (c == 1 && i == 2)
                    step("clr_ignored", GREEN, RED, 1'b1, mk(GREEN, RED, 1'b0, 3'd0, 1'b0));
                else
                    pass("nom_a_green", GREEN, RED);
            end
            for (int i = 0; i < 3; i++) pass("nom_a_yellow", YELLOW, RED);
            for (int i = 0; i < 6; i++) pass("nom_b_green", RED, GREEN);
            for (int i = 0; i < 3; i++) pass("nom_b_yellow", RED, YELLOW);
        end

        // Single-cycle conflict: safe substitute, no fault
        step("conflict_1cyc", YELLOW, YELLOW, 1'b0, mk(RED, RED, 1'b0, 3'd0, 1'b0));
        pass("post_conflict", YELLOW, RED);
        pass("post_conflict", YELLOW, RED);
        pass("post_conflict", RED, GREEN);

        // Persistent conflict latches code 2, then flash pattern
        step("conflict_c1", GREEN, GREEN, 1'b0, mk(RED, RED, 1'b0, 3'd0, 1'b0));
        step("conflict_latch", GREEN, GREEN, 1'b0, mk(RED, RED, 1'b1, 3'd2, 1'b1));
        flash_run("flash", 9, 3'd2);
        recover();

        // Invalid together with a non-red road: invalid has priority
        step("invalid_c1", 3'b011, GREEN, 1'b0, mk(RED, RED, 1'b0, 3'd0, 1'b0));
        step("invalid_latch", 3'b011, GREEN, 1'b0, mk(RED, RED, 1'b1, 3'd1, 1'b1));
        flash_run("flash_inv", 1, 3'd1);
        recover();

        // Short yellow: two yellow cycles then red
        pass("short_y", YELLOW, RED);
        pass("short_y", YELLOW, RED);
        step("short_y_latch", RED, RED, 1'b0, mk(RED, RED, 1'b1, 3'd3, 1'b1));
        recover();

        // Skipped yellow: green straight to red
        step("skip_y_latch", RED, RED, 1'b0, mk(RED, RED, 1'b1, 3'd4, 1'b1));
        flash_run("flash_skip", 5, 3'd4);

        // Asynchronous reset in the middle of FLASH
        #2 reset = 1'b1;
        #1;
        expect_push("async_reset", mk(RED, RED, 1'b0, 3'd0, 1'b0));
        compare_front();
        @(posedge clk);
        #2 reset = 1'b0;
        pass("after_reset", GREEN, RED);
        pass("after_reset", YELLOW, RED);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
Downstream safety stage between the traffic light sequencer and the lamp drivers. It samples the sequencer's per-road one-hot light codes and forwards them to the lamps with one cycle of latency. It detects illegal light patterns and unsafe sequences. On a confirmed fault it latches a fault code and forces red-flash mode until an operator clears it, then resynchronises to the sequencer's start of cycle.

Parameters:
PERSIST_CYC, 2, consecutive sampled cycles a level fault (invalid or conflict) must hold before it is latched; legal range >=1
MIN_YELLOW, 3, minimum consecutive yellow cycles required before a yellow->red transition; legal range >=1
FLASH_HALF, 4, cycles per half-period of red flash; legal range >=1

Ports:
clk  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-high
roadA_in  input  3  sequencer code for road A (RED=100, YELLOW=010, GREEN=001)
roadB_in  input  3  sequencer code for road B, same encoding
fault_clear  input  1  operator clear, single-cycle pulse or level; acted on only in FLASH
lampA  output  3  registered lamp drive, road A
lampB  output  3  registered lamp drive, road B
fault  output  1  latched fault indicator
fault_code  output  3  0 none, 1 invalid encoding, 2 conflict, 3 short yellow, 4 skipped yellow
flash_mode  output  1  high while in FLASH

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state=MONITOR; lampA=lampB=100; fault=0; fault_code=0; flash_mode=0.
  - prevA=prevB=100; yellow counters=0; persistence counter=0; flash counter=0.
- State MONITOR, per edge:
  - invalid = either input not in {100,010,001}.
  - conflict = both inputs valid and neither equal to 100.
  - If invalid or conflict: lamps<=100/100 (safe substitute) and persistence counter increments. Otherwise lamps<=inputs and the counter clears.
  - Level fault latches at the edge where the counter reaches PERSIST_CYC.
  - Per road: yellow counter increments while input is 010, saturating at MIN_YELLOW, and clears otherwise.
  - Event faults, evaluated against the prev register:
    - prev=010 and cur=100 with yellow count < MIN_YELLOW -> code 3.
    - prev=001 and cur=100 -> code 4.
  - Priority when several faults occur on the same edge: lowest code wins (1>2>3>4).
  - On any fault: state<=FLASH; fault<=1; fault_code<=code; flash_mode<=1; flash counter<=0; lamps<=100/100.
  - fault_clear is ignored in MONITOR.
- State FLASH:
  - Both lamps alternate 100 and 000. Each phase lasts FLASH_HALF cycles; the first phase is 100.
  - Faults are not re-evaluated; fault_code stays held.
  - fault_clear=1 -> next edge: state<=WAIT_SYNC; fault<=0; fault_code<=0; flash_mode<=0; lamps<=100/100.
- State WAIT_SYNC:
  - Lamps held at 100/100; no fault evaluation; yellow and persistence counters held at 0.
  - When sampled roadA_in=001 and roadB_in=100: state<=MONITOR, and on that same edge lamps<=inputs.
- prev registers update every edge in every state.
- Latency: input to lamp is 1 cycle in MONITOR. A fault is visible on fault/lamps after the detecting edge.
- Reset mid-operation (any state): immediate return to reset values; a fault is not preserved across reset.

Decomposition:
- Shared package traffic_pkg holds:
  - light encodings RED/YELLOW/GREEN/OFF (3 bits);
  - fault code enum (NONE, INVALID, CONFLICT, SHORT_YELLOW, SKIP_YELLOW);
  - monitor state enum (MONITOR, FLASH, WAIT_SYNC).
- One sub-module, tcm_flash_timer: a FLASH_HALF counter with clear and enable, producing the phase bit.

Test Plan:
- Nominal: 3 full sequencer cycles (A green 6, yellow 3; B green 6, yellow 3) -> lamps equal inputs delayed 1 cycle; fault=0 throughout.
- Conflict: 001/001 for 1 cycle -> lamps 100/100 that cycle, no fault. Repeat for 2 cycles -> fault=1, fault_code=2, flash_mode=1.
- Invalid: roadA_in=011 for 2 cycles together with B=001 (invalid and conflict both present) -> fault_code=1 (priority).
- Short yellow: A yellow 2 cycles then 100 -> fault_code=3 after the red sample. Direct A 001->100 -> fault_code=4.
- Flash and recovery, FLASH_HALF=4: lamps 100 x4, 000 x4, repeating. Pulse fault_clear -> lamps 100/100, fault=0. Hold A=010 -> still WAIT_SYNC. Apply A=001/B=100 -> MONITOR, lamps 001/100 next edge.
- Reset asserted mid-FLASH, asynchronously -> lamps 100/100, fault=0, fault_code=0, flash_mode=0 without waiting for a clock edge.
